cacheline_burst_adaptor: RTL and testbench

//  Sits between the cache controller's physical-memory port and the burst-based main memory.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cacheline_burst_adaptor.sv | 130 +++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache-line to memory-burst adaptor.
// The adaptor's parameters default to these values so the cache and memory sides agree on geometry.
package cache_pkg;

    localparam int LINE_W   = 256;
    localparam int BURST_W  = 64;
    localparam int ADDR_W   = 32;
    localparam int BURSTS   = LINE_W / BURST_W;
    localparam int OFFSET_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage : cache_pkg

// File: rtl/cacheline_burst_adaptor.sv
// Converts single full-line cache reads/writes into BURSTS memory beats of BURST_W bits each,
// answering the cache with a one-cycle resp_o once the whole line has moved.
module cacheline_burst_adaptor #(
    parameter int LINE_W  = cache_pkg::LINE_W,
    parameter int BURST_W = cache_pkg::BURST_W,
    parameter int ADDR_W  = cache_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    import cache_pkg::*;

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_W / 8 - 1);

    adaptor_state_t     r_state;
    adaptor_state_t     w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_buf;
    logic [LINE_W-1:0]  r_line;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINE_W-1:0]  w_buf_fill;
    logic               w_last;
    logic               w_busy;
    logic               w_latch_wr;
    logic               w_latch_rd;

    assign w_busy    = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_last    = resp_i && (r_cnt == CNT_W'(BEATS - 1));
    assign address_o = r_addr;
    assign line_o    = r_line;

    // Shared buffer with the current beat slotted in; used for read assembly.
    always_comb begin
        w_buf_fill = r_buf;
        w_buf_fill[int'(r_cnt)*BURST_W +: BURST_W] = burst_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        burst_o      = '0;
        w_latch_wr   = 1'b0;
        w_latch_rd   = 1'b0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_latch_wr   = 1'b1;
                    w_state_next = WR_BURST;
                end else if (read_i) begin
                    w_latch_rd   = 1'b1;
                    w_state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            WR_BURST: begin
                write_o = 1'b1;
                burst_o = r_buf[int'(r_cnt)*BURST_W +: BURST_W];
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                resp_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // line_o is a separate holding register so it only changes when a read completes,
    // even though the shared buffer is reused to hold write-back data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            if (w_latch_wr) begin
                r_buf  <= line_i;
                r_addr <= address_i & ~OFS_MASK;
            end else if (w_latch_rd) begin
                r_addr <= address_i & ~OFS_MASK;
            end

            if (w_busy && resp_i) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (r_state == RD_BURST) begin
                    r_buf <= w_buf_fill;
                    if (w_last) begin
                        r_line <= w_buf_fill;
                    end
                end
            end
        end
    end

endmodule : cacheline_burst_adaptor

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: directed scenarios plus randomized transfers
// checked against a line/beat reference model.
module tb_cacheline_burst_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    int errors = 0;
    int checks = 0;
    int resp_pulses = 0;
    logic [LW-1:0] exp_line;

    cacheline_burst_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resp_o === 1'b1) resp_pulses <= resp_pulses + 1;
    end

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        logic [AW-1:0] mask;
        mask = AW'(LW / 8 - 1);
        return a & ~mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [BW-1:0] beats [NB],
                           input int maxgap, input bit stray_done, input string tag);
        logic [LW-1:0] exp;
        int p0;
        int g;
        for (int k = 0; k < NB; k++) exp[k*BW +: BW] = beats[k];
        p0 = resp_pulses;
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
        step();
        checks++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_start: read_o=%b write_o=%b required 1/0", tag, read_o, write_o);
        end
        checks++;
        if (address_o !== align(addr)) begin
            errors++;
            $display("FAIL %s rd_addr: address_o=%h required %h", tag, address_o, align(addr));
        end
        for (int k = 0; k < NB; k++) begin
            g = $urandom_range(0, maxgap);
            for (int j = 0; j < g; j++) begin
                resp_i = 1'b0; burst_i = {$urandom, $urandom}; address_i = $urandom;
                step();
                checks++;
                if (read_o !== 1'b1 || resp_o !== 1'b0 || address_o !== align(addr)) begin
                    errors++;
                    $display("FAIL %s rd_gap%0d: read_o=%b resp_o=%b address_o=%h required 1/0/%h",
                             tag, k, read_o, resp_o, address_o, align(addr));
                end
            end
            resp_i = 1'b1; burst_i = beats[k];
            step();
            if (k < NB - 1) begin
                checks++;
                if (read_o !== 1'b1 || resp_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s rd_beat%0d: read_o=%b resp_o=%b required 1/0", tag, k, read_o, resp_o);
                end
            end
        end
        resp_i = stray_done; burst_i = {$urandom, $urandom};
        checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_done: resp_o=%b read_o=%b required 1/0", tag, resp_o, read_o);
        end
        checks++;
        if (line_o !== exp) begin
            errors++;
            $display("FAIL %s rd_line: line_o=%h required %h", tag, line_o, exp);
        end
        exp_line = exp;
        step();
        resp_i = 1'b0; read_i = 1'b0;
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line) begin
            errors++;
            $display("FAIL %s rd_idle: resp_o=%b read_o=%b write_o=%b line_o=%h required 0/0/0/%h",
                     tag, resp_o, read_o, write_o, line_o, exp_line);
        end
        checks++;
        if (resp_pulses - p0 != 1) begin
            errors++;
            $display("FAIL %s rd_pulses: got %0d resp pulses required 1", tag, resp_pulses - p0);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input int maxgap, input bit both, input string tag);
        int p0;
        int g;
        p0 = resp_pulses;
        write_i = 1'b1; read_i = both; address_i = addr; line_i = line; resp_i = 1'b0;
        step();
        checks++;
        if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== align(addr)) begin
            errors++;
            $display("FAIL %s wr_start: write_o=%b read_o=%b address_o=%h required 1/0/%h",
                     tag, write_o, read_o, address_o, align(addr));
        end
        for (int k = 0; k < NB; k++) begin
            g = $urandom_range(0, maxgap);
            for (int j = 0; j < g; j++) begin
                resp_i = 1'b0; line_i = {8{$urandom}}; address_i = $urandom;
                checks++;
                if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== line[k*BW +: BW]) begin
                    errors++;
                    $display("FAIL %s wr_gap%0d: write_o=%b read_o=%b burst_o=%h required 1/0/%h",
                             tag, k, write_o, read_o, burst_o, line[k*BW +: BW]);
                end
                step();
            end
            resp_i = 1'b1;
            checks++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== line[k*BW +: BW]) begin
                errors++;
                $display("FAIL %s wr_beat%0d: write_o=%b read_o=%b resp_o=%b burst_o=%h required 1/0/0/%h",
                         tag, k, write_o, read_o, resp_o, burst_o, line[k*BW +: BW]);
            end
            step();
        end
        resp_i = 1'b0;
        checks++;
        if (resp_o !== 1'b1 || write_o !== 1'b0 || read_o !== 1'b0 || burst_o !== '0) begin
            errors++;
            $display("FAIL %s wr_done: resp_o=%b write_o=%b read_o=%b burst_o=%h required 1/0/0/0",
                     tag, resp_o, write_o, read_o, burst_o);
        end
        checks++;
        if (line_o !== exp_line) begin
            errors++;
            $display("FAIL %s wr_line_hold: line_o=%h required %h", tag, line_o, exp_line);
        end
        step();
        write_i = 1'b0; read_i = 1'b0;
        checks++;
        if (resp_o !== 1'b0 || write_o !== 1'b0 || read_o !== 1'b0 || resp_pulses - p0 != 1) begin
            errors++;
            $display("FAIL %s wr_idle: resp_o=%b write_o=%b read_o=%b pulses=%0d required 0/0/0/1",
                     tag, resp_o, write_o, read_o, resp_pulses - p0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b1;
        line_i = '0; address_i = 32'hFFFF_FFFF; burst_i = '1;
        repeat (3) step();
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== '0 ||
            address_o !== '0 || line_o !== '0) begin
            errors++;
            $display("FAIL reset: read_o=%b write_o=%b resp_o=%b burst_o=%h address_o=%h line_o=%h required all 0",
                     read_o, write_o, resp_o, burst_o, address_o, line_o);
        end
        read_i = 1'b0; resp_i = 1'b0;
        rst = 1'b0;
        exp_line = '0;
        step();
    endtask

    task automatic test_read_directed();
        logic [BW-1:0] b [NB];
        b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
        b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
        checks++;
        if (align(32'h0000_1234) !== 32'h0000_1220) begin
            errors++;
            $display("FAIL model_align: got %h required 00001220", align(32'h0000_1234));
        end
        do_read(32'h0000_1234, b, 0, 1'b0, "read_directed");
    endtask

    task automatic test_write_gaps();
        logic [LW-1:0] l;
        l = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        do_write(32'h0000_ABCD, l, 2, 1'b0, "write_gaps");
    endtask

    task automatic test_both_high();
        logic [LW-1:0] l;
        l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write($urandom, l, 1, 1'b1, "both_high");
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] l;
        logic [BW-1:0] b [NB];
        l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NB; k++) b[k] = {$urandom, $urandom};
        do_write($urandom, l, 1, 1'b0, "b2b_wb");
        do_read($urandom, b, 1, 1'b0, "b2b_fill");
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] b [NB];
        int p0;
        p0 = resp_pulses;
        read_i = 1'b1; address_i = 32'h8000_0040;
        step();
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || address_o !== '0 ||
            line_o !== '0 || burst_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: read_o=%b resp_o=%b address_o=%h line_o=%h required all 0",
                     read_o, resp_o, address_o, line_o);
        end
        exp_line = '0;
        step();
        read_i = 1'b0; resp_i = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (resp_pulses != p0 || read_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_resp: pulses=%0d read_o=%b required 0/0", resp_pulses - p0, read_o);
        end
        for (int k = 0; k < NB; k++) b[k] = {$urandom, $urandom};
        do_read(32'h8000_0040, b, 2, 1'b0, "reset_mid_fresh");
    endtask

    task automatic test_stray_resp();
        logic [BW-1:0] b [NB];
        int p0;
        p0 = resp_pulses;
        for (int j = 0; j < 3; j++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            step();
        end
        resp_i = 1'b0;
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || resp_pulses != p0 ||
            line_o !== exp_line) begin
            errors++;
            $display("FAIL stray_idle: read_o=%b write_o=%b resp_o=%b pulses=%0d line_o=%h required 0/0/0/0/%h",
                     read_o, write_o, resp_o, resp_pulses - p0, line_o, exp_line);
        end
        for (int k = 0; k < NB; k++) b[k] = {$urandom, $urandom};
        do_read($urandom, b, 0, 1'b1, "stray_done");
        for (int k = 0; k < NB; k++) b[k] = {$urandom, $urandom};
        do_read($urandom, b, 1, 1'b0, "after_stray");
    endtask

    task automatic test_random();
        logic [BW-1:0] b [NB];
        logic [LW-1:0] l;
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < NB; k++) b[k] = {$urandom, $urandom};
                do_read($urandom, b, 3, 1'b0, "rand_read");
            end else begin
                l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                do_write($urandom, l, 3, 1'b0, "rand_write");
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_directed();
        test_write_gaps();
        test_both_high();
        test_back_to_back();
        test_reset_mid();
        test_stray_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cacheline_burst_adaptor
